// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding for the sequential ALU blocks
// and the default datapath width.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ALU_W = 8;

endpackage

// File: rtl/sub1b.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow-out bo.
module sub1b (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor r = a - b - bin, LSB first, one bit per clock.
// Optional zero/overflow flags are built when SUB_SERIAL_FLAGS_EN is defined.
module sub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             bout
`ifdef SUB_SERIAL_FLAGS_EN
    ,
    output logic             zf,
    output logic             vf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    sub1b u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // busy/done are derived from the FSM but registered, so they never
    // overlap and carry no combinational path from start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            r      <= '0;
            bout   <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        r      <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bo_bit;
                    r      <= {d_bit, r[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    bout <= borrow;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_SERIAL_FLAGS_EN
    // Operand MSBs are shifted out during RUN, so keep them for the overflow flag.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zf    <= 1'b0;
            vf    <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                zf    <= 1'b0;
                vf    <= 1'b0;
            end else if (state == ST_DONE) begin
                zf <= (r == '0);
                vf <= (a_msb != b_msb) && (r[WIDTH-1] != a_msb);
            end
        end
    end
`endif

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial subtractor for the ALU. It computes `a - b - bin` one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a borrow register. It is the inverse-direction companion of the ALU's 1-bit full-adder cell. The ALU control logic drives it with a start/done handshake when area matters more than latency.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: request a subtraction; sampled only in IDLE.
- `a` input, WIDTH bits: minuend; captured on an accepted `start`.
- `b` input, WIDTH bits: subtrahend; captured on an accepted `start`.
- `bin` input, 1 bit: borrow-in; captured on an accepted `start`.
- `busy` output, 1 bit: high while an operation is in progress (RUN).
- `done` output, 1 bit: one-cycle pulse when the result is valid.
- `r` output, WIDTH bits: difference; holds its value until the next accepted `start`.
- `bout` output, 1 bit: final borrow-out.
- `zf` output, 1 bit: zero flag (only when `SUB_SERIAL_FLAGS_EN` is defined).
- `vf` output, 1 bit: signed-overflow flag (only when `SUB_SERIAL_FLAGS_EN` is defined).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start=1`: latch `a`, `b` into shift registers; borrow register ← `bin`; bit counter ← 0; clear `r`; go to RUN.
  - On `start=0`: stay in IDLE.
- RUN, each cycle, with `x` = `a_sh[0]`, `y` = `b_sh[0]`, `c` = borrow:
  - `d = x ^ y ^ c`
  - `c' = (~x & y) | (~(x ^ y) & c)`
  - `d` shifts into `r` from the MSB side; `a_sh` and `b_sh` shift right; counter increments.
  - When the counter reaches `WIDTH-1`, that cycle's bit is the last one; go to DONE.
- DONE: `done=1` for exactly one cycle; `bout` ← borrow register; go to IDLE.
- Arithmetic result:
  - `r = (a - b - bin) mod 2^WIDTH`.
  - `bout=1` iff unsigned `a < b + bin`.
- `start` during RUN or DONE is ignored; operands are not re-sampled.
- `start` held high in IDLE starts a new operation on the cycle after DONE.
- Input changes after acceptance have no effect on the running operation.
- Reset mid-operation aborts immediately. All outputs return to reset values; no `done` is produced.
- Reset values:
  - state = IDLE
  - `busy=0`, `done=0`, `r=0`, `bout=0`, `zf=0`, `vf=0`
  - shift registers, counter and borrow register all 0.

## Timing
- `start` accepted at rising edge 0 → `busy=1` from edge 0 through edge WIDTH.
- `done=1` and a valid `r`/`bout`/flags after edge WIDTH+1; `done` lasts one cycle.
- Total latency is WIDTH+1 cycles; throughput is one operation per WIDTH+2 cycles minimum.
- `done` and `busy` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SUB_SERIAL_FLAGS_EN`.
- Defined:
  - `zf` and `vf` exist.
  - Both update together with `done`: `zf = (r == 0)`, `vf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB])`.
  - The original operand MSBs are kept in two extra flops.
  - Flags hold until the next accepted `start`, which clears them.
- Undefined: the `zf` and `vf` ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`)
  - the default width constant `ALU_W = 8`.
- Counter width is `$clog2(WIDTH)`, derived locally.
- One sub-module, `sub1b`: a combinational 1-bit full subtractor.
  - Inputs: `a`, `b`, `bi`. Outputs: `d`, `bo`.
  - Instantiated once; the borrow flop is in `sub_serial`.

## Test plan
- `a=8'h05, b=8'h03, bin=0`, start at cycle 0 → `done` at cycle 9; `r=8'h02`, `bout=0`, `zf=0`, `vf=0`.
- `a=8'h00, b=8'h01, bin=0` → `r=8'hFF`, `bout=1`, `vf=0`.
- `a=8'h80, b=8'h01, bin=0` → `r=8'h7F`, `bout=0`, `vf=1`. Then `a=b=8'h10, bin=1` → `r=8'hFF`, `bout=1`.
- `a=b=8'h3C, bin=0` → `r=8'h00`, `zf=1`, `bout=0`.
- Pulse `start` with new operands at cycles 3 and 9 of a running op → both ignored; the original result is returned; `busy` is unchanged.
- Assert `rst_n=0` at cycle 4 of an operation → all outputs 0 immediately; no `done`. A following op with `a=8'h0A, b=8'h04` → `r=8'h06`.
